// File: rtl/aibnd_rxen_pkg.sv
// Shared state encoding and default counter width for the RX enable sequencer.
package aibnd_rxen_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLK_UP = 3'd1,
    ST_DAT_UP = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

endpackage

// File: rtl/aibnd_rxen_reqfilt.sv
// Request conditioner: 2-flop synchronizer followed by a 2-sample agreement filter.
// Used by aibnd_rxen_seq when AIBND_RXEN_SEQ_REQ_FILT_EN is defined.
module aibnd_rxen_reqfilt (
  input  logic clk,
  input  logic rst_n,
  input  logic req_in,
  output logic req_out
);

  logic sync1;
  logic sync2;
  logic sync3;
  logic held;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      held  <= 1'b0;
    end else begin
      sync1 <= req_in;
      sync2 <= sync1;
      sync3 <= sync2;
      held  <= req_out;
    end
  end

  // Output only moves once two consecutive synchronized samples agree.
  assign req_out = (sync2 == sync3) ? sync2 : held;

endmodule

// File: rtl/aibnd_rxen_seq.sv
// RX pad path enable sequencer: clock-path enable, then data-path enable, then ready.
// Optional request filter selected by macro AIBND_RXEN_SEQ_REQ_FILT_EN.
module aibnd_rxen_seq
  import aibnd_rxen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_req,
  input  logic             cfg_clk_pin,
  input  logic             cfg_dat_pin,
  input  logic [CNT_W-1:0] cfg_dly,
  output logic             clk_en,
  output logic             data_en,
  output logic             rx_rdy,
  output logic             busy
);

  logic             req;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] dly_q;
  logic             clk_pin_q;
  logic             dat_pin_q;
  logic             latch_en;

`ifdef AIBND_RXEN_SEQ_REQ_FILT_EN
  aibnd_rxen_reqfilt u_reqfilt (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (rx_req),
    .req_out (req)
  );
`else
  assign req = rx_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dly_q     <= '0;
      clk_pin_q <= 1'b0;
      dat_pin_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch_en) begin
        dly_q     <= cfg_dly;
        clk_pin_q <= cfg_clk_pin;
        dat_pin_q <= cfg_dat_pin;
      end
    end
  end

  // Counter saturates at zero; each stage reloads from the latched delay.
  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt != '0) ? cnt - CNT_W'(1) : '0;
    latch_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nx = ST_CLK_UP;
          cnt_nx   = cfg_dly;
          latch_en = 1'b1;
        end
      end
      ST_CLK_UP: begin
        if (!req) begin
          state_nx = ST_DRAIN;
          cnt_nx   = dly_q;
        end else if (cnt == '0) begin
          state_nx = ST_DAT_UP;
          cnt_nx   = dly_q;
        end
      end
      ST_DAT_UP: begin
        if (!req) begin
          state_nx = ST_DRAIN;
          cnt_nx   = dly_q;
        end else if (cnt == '0) begin
          state_nx = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!req) begin
          state_nx = ST_DRAIN;
          cnt_nx   = dly_q;
        end
      end
      ST_DRAIN: begin
        if (cnt == '0) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are a registered decode of the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_en  <= 1'b0;
      data_en <= 1'b0;
      rx_rdy  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      clk_en  <= clk_pin_q && (state inside {ST_CLK_UP, ST_DAT_UP, ST_ACTIVE, ST_DRAIN});
      data_en <= dat_pin_q && (state inside {ST_DAT_UP, ST_ACTIVE});
      rx_rdy  <= (state == ST_ACTIVE);
      busy    <= (state inside {ST_CLK_UP, ST_DAT_UP, ST_DRAIN});
    end
  end

endmodule

// File: tb/tb_aibnd_rxen_seq.sv
// Directed, scoreboard-based bench for aibnd_rxen_seq.
// Expected output vectors are {busy, rx_rdy, data_en, clk_en}, one per clock.
module tb_aibnd_rxen_seq;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             rx_req;
  logic             cfg_clk_pin;
  logic             cfg_dat_pin;
  logic [CNT_W-1:0] cfg_dly;
  logic             clk_en;
  logic             data_en;
  logic             rx_rdy;
  logic             busy;

  int checks = 0;
  int fails  = 0;
  logic [3:0] sb[$];

  aibnd_rxen_seq #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_req      (rx_req),
    .cfg_clk_pin (cfg_clk_pin),
    .cfg_dat_pin (cfg_dat_pin),
    .cfg_dly     (cfg_dly),
    .clk_en      (clk_en),
    .data_en     (data_en),
    .rx_rdy      (rx_rdy),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic req, input logic cpin, input logic dpin,
                               input logic [CNT_W-1:0] dly);
    rx_req      = req;
    cfg_clk_pin = cpin;
    cfg_dat_pin = dpin;
    cfg_dly     = dly;
  endtask

  task automatic push(input int n, input logic [3:0] v);
    for (int i = 0; i < n; i++) sb.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] obs;
    logic [3:0] exp;
    obs = {busy, rx_rdy, data_en, clk_en};
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("[TB] FAIL %s: observed {busy,rdy,den,cen}=%b expected %b", tag, obs, exp);
      end
    end
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    push(2, 4'b0000);
    runCycles(2, "reset_state");
    rst_n = 1'b1;

`ifndef AIBND_RXEN_SEQ_REQ_FILT_EN
    // Clock-only pad, 4-cycle stages; cfg_dly changes mid-sequence without effect.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd3);
    push(1, 4'b0000);
    push(8, 4'b1001);
    push(1, 4'b0101);
    runCycles(3, "clk_only_up");
    cfg_dly = 8'd7;
    runCycles(7, "clk_only_up");
    push(2, 4'b0101);
    runCycles(2, "clk_only_active");
    rx_req = 1'b0;
    push(1, 4'b0101);
    push(4, 4'b1001);
    push(2, 4'b0000);
    runCycles(7, "clk_only_drain");

    // Both pins, zero delay: up, then down after ready.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd0);
    push(1, 4'b0000);
    push(1, 4'b1001);
    push(1, 4'b1011);
    push(3, 4'b0111);
    runCycles(6, "both_dly0_up");
    rx_req = 1'b0;
    push(1, 4'b0111);
    push(1, 4'b1001);
    push(1, 4'b0000);
    runCycles(3, "both_dly0_down");

    // Request dropped during DAT_UP.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd2);
    push(1, 4'b0000);
    push(3, 4'b1001);
    push(1, 4'b1011);
    push(3, 4'b1001);
    push(1, 4'b0000);
    runCycles(4, "abort_datup");
    rx_req = 1'b0;
    runCycles(5, "abort_datup");

    // Request re-raised during DRAIN restarts one cycle after IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd1);
    push(1, 4'b0000);
    push(4, 4'b1001);
    push(1, 4'b0101);
    push(2, 4'b1001);
    push(1, 4'b0000);
    push(1, 4'b1001);
    runCycles(5, "reraise");
    rx_req = 1'b0;
    runCycles(1, "reraise");
    rx_req = 1'b1;
    runCycles(4, "reraise");
    push(3, 4'b1001);
    push(1, 4'b0101);
    runCycles(4, "restart_active");

    // Reset while ACTIVE, then request sampled on first edge out of reset.
    rst_n = 1'b0;
    push(1, 4'b0000);
    runCycles(1, "reset_active");
    rst_n = 1'b1;
    push(1, 4'b0000);
    push(1, 4'b1001);
    runCycles(2, "post_reset_up");
    rx_req = 1'b0;
    push(3, 4'b1001);
    push(1, 4'b0000);
    runCycles(4, "post_reset_drain");

    // Both pins low: sequence runs with enables held low.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    push(1, 4'b0000);
    push(2, 4'b1000);
    push(1, 4'b0100);
    runCycles(4, "no_pins_up");
    rx_req = 1'b0;
    push(1, 4'b0100);
    push(1, 4'b1000);
    push(1, 4'b0000);
    runCycles(3, "no_pins_down");
`else
    // One-cycle request pulse must be rejected by the filter.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd0);
    push(9, 4'b0000);
    runCycles(1, "filt_pulse");
    rx_req = 1'b0;
    runCycles(8, "filt_pulse");

    // Held request: ready arrives 3 cycles later than unfiltered.
    rx_req = 1'b1;
    push(4, 4'b0000);
    push(1, 4'b1001);
    push(1, 4'b1011);
    push(1, 4'b0111);
    runCycles(7, "filt_held");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
